// File: rtl/rsa_display_pkg.sv
// Shared constants for the RSA front-panel display path: glyph codes, scanner states, anode level.
package rsa_display_pkg;

  localparam logic [3:0] DASH    = 4'hA;
  localparam logic [3:0] FOUND   = 4'hB;
  localparam logic [3:0] CRYPT   = 4'hC;
  localparam logic [3:0] KEY_N   = 4'hD;
  localparam logic [3:0] KEY_D   = 4'hE;
  localparam logic [3:0] UNCRYPT = 4'hF;

  localparam logic ANODE_OFF = 1'b1;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scanState_e;

endpackage

// File: rtl/display_scanner.sv
// Multiplexes N packed digit codes onto one seven-segment decoder with a blanking gap per digit.
// Optional digit blinking is built only when SCANNER_BLINK_EN is defined.
module display_scanner
  import rsa_display_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 8,
  parameter int unsigned DIG_TICKS    = 100000,
  parameter int unsigned BLANK_TICKS  = 1000,
  parameter int unsigned BLINK_FRAMES = 250
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp_mask,
  input  logic [N_DIGITS-1:0]   en_mask,
  input  logic [N_DIGITS-1:0]   blink_mask,
  output logic [3:0]            bcd,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   anode,
  output logic                  frame_start
);

  localparam int unsigned MAX_TICKS = (DIG_TICKS > BLANK_TICKS) ? DIG_TICKS : BLANK_TICKS;
  localparam int unsigned CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam int unsigned IDX_W     = $clog2(N_DIGITS);

  scanState_e state;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idxNext;
  logic                  idxWrap;
  logic [CNT_W-1:0]      tickCnt;
  logic                  blankDone;
  logic                  showDone;
  logic [4*N_DIGITS-1:0] shDigits;
  logic [N_DIGITS-1:0]   shDp;
  logic [N_DIGITS-1:0]   shEn;
  logic                  digitLit;
  logic [N_DIGITS-1:0]   showAnode;

`ifdef SCANNER_BLINK_EN
  localparam int unsigned FC_W = $clog2(BLINK_FRAMES + 1);

  logic [N_DIGITS-1:0] shBlink;
  logic                blinkPhase;
  logic                phaseNext;
  logic                phaseWrap;
  logic [FC_W-1:0]     frameCnt;

  // Phase flips as the frame after every BLINK_FRAMES frames begins, so a frame is never split.
  always_comb begin
    phaseWrap = (idx == '0) && (frameCnt == FC_W'(BLINK_FRAMES));
    phaseNext = phaseWrap ? ~blinkPhase : blinkPhase;
  end
`else
  logic unusedBlink;
  assign unusedBlink = ^{blink_mask, 32'(BLINK_FRAMES)};
`endif

  always_comb begin
    blankDone = (tickCnt == CNT_W'(BLANK_TICKS - 1));
    showDone  = (tickCnt == CNT_W'(DIG_TICKS - 1));
    idxWrap   = (idx == IDX_W'(N_DIGITS - 1));
    idxNext   = idxWrap ? '0 : idx + IDX_W'(1);
  end

  // Anode pattern loaded on BLANK->SHOW; a dark digit still occupies its slot.
  always_comb begin
    digitLit = shEn[idx];
`ifdef SCANNER_BLINK_EN
    if (phaseNext && shBlink[idx]) digitLit = 1'b0;
`endif
    showAnode = {N_DIGITS{ANODE_OFF}};
    if (digitLit) showAnode[idx] = ~ANODE_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      idx         <= '0;
      tickCnt     <= '0;
      shDigits    <= '0;
      shDp        <= '0;
      shEn        <= '0;
      bcd         <= 4'h0;
      dp          <= 1'b1;
      anode       <= {N_DIGITS{ANODE_OFF}};
      frame_start <= 1'b0;
`ifdef SCANNER_BLINK_EN
      shBlink     <= '0;
      blinkPhase  <= 1'b0;
      frameCnt    <= '0;
`endif
    end else begin
      frame_start <= 1'b0;
      case (state)
        INIT: begin
          shDigits <= digits;
          shDp     <= dp_mask;
          shEn     <= en_mask;
`ifdef SCANNER_BLINK_EN
          shBlink  <= blink_mask;
`endif
          bcd      <= digits[3:0];
          dp       <= ~dp_mask[0];
          tickCnt  <= '0;
          state    <= BLANK;
        end
        BLANK: begin
          if (blankDone) begin
            tickCnt     <= '0;
            anode       <= showAnode;
            frame_start <= (idx == '0);
            state       <= SHOW;
`ifdef SCANNER_BLINK_EN
            if (idx == '0) begin
              blinkPhase <= phaseNext;
              frameCnt   <= phaseWrap ? FC_W'(1) : frameCnt + FC_W'(1);
            end
`endif
          end else begin
            tickCnt <= tickCnt + CNT_W'(1);
          end
        end
        SHOW: begin
          if (showDone) begin
            tickCnt <= '0;
            anode   <= {N_DIGITS{ANODE_OFF}};
            idx     <= idxNext;
            state   <= BLANK;
            // Wrap takes a fresh snapshot so the next frame is never torn.
            if (idxWrap) begin
              shDigits <= digits;
              shDp     <= dp_mask;
              shEn     <= en_mask;
`ifdef SCANNER_BLINK_EN
              shBlink  <= blink_mask;
`endif
              bcd      <= digits[3:0];
              dp       <= ~dp_mask[0];
            end else begin
              bcd      <= shDigits[{idxNext, 2'b00} +: 4];
              dp       <= ~shDp[idxNext];
            end
          end else begin
            tickCnt <= tickCnt + CNT_W'(1);
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner (N=4, DIG=4, BLANK=2, BLINK_FRAMES=2); honours SCANNER_BLINK_EN.
module tb_display_scanner;

  localparam int N     = 4;
  localparam int DIG   = 4;
  localparam int BLK   = 2;
  localparam int BFR   = 2;
  localparam int SLOT  = DIG + BLK;
  localparam int FRAME = N * SLOT;
  localparam int NV    = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [4*N-1:0] digits;
  logic [N-1:0]  dp_mask, en_mask, blink_mask;
  logic [3:0]    bcd;
  logic          dp;
  logic [N-1:0]  anode;
  logic          frame_start;

  display_scanner #(
    .N_DIGITS(N), .DIG_TICKS(DIG), .BLANK_TICKS(BLK), .BLINK_FRAMES(BFR)
  ) dut (
    .clk(clk), .rst(rst), .digits(digits), .dp_mask(dp_mask), .en_mask(en_mask),
    .blink_mask(blink_mask), .bcd(bcd), .dp(dp), .anode(anode), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dpMask;
    logic [3:0]  enMask;
    logic [3:0]  blink;
    logic [15:0] expBcd;   // slot-ordered codes, slot 0 in the low nibble
    logic [3:0]  expDpN;   // active-low dp per slot
    logic [3:0]  expLit;   // slots whose anode goes low (before blinking)
  } vec_t;

  typedef struct {
    logic [3:0] anode;
    logic [3:0] bcd;
    logic       dp;
    logic       fs;
  } exp_t;

  vec_t vecs [NV];
  exp_t sbq [$];
  int nCompared   = 0;
  int nMismatched = 0;

  task automatic driveVec(input vec_t v);
    digits     = v.digits;
    dp_mask    = v.dpMask;
    en_mask    = v.enMask;
    blink_mask = v.blink;
  endtask

  // Expected output for every cycle of one frame, derived from slot timing.
  task automatic pushFrame(input vec_t v, input int frameNo);
    for (int p = 0; p < FRAME; p++) begin
      exp_t e;
      int   slot;
      int   w;
      logic lit;
      logic [15:0] codes;
      slot  = p / SLOT;
      w     = p % SLOT;
      codes = v.expBcd;
      e.bcd = codes[4*slot +: 4];
      e.dp  = v.expDpN[slot];
      lit   = (w >= BLK) && v.expLit[slot];
`ifdef SCANNER_BLINK_EN
      if (((frameNo / BFR) % 2) == 1 && v.blink[slot]) lit = 1'b0;
`endif
      e.anode = 4'hF;
      if (lit) e.anode[slot] = 1'b0;
      e.fs = (p == BLK);
      sbq.push_back(e);
    end
    if (frameNo < 0) $display("unexpected frame number %0d", frameNo);
  endtask

  task automatic checkCycle(input string tag, input int f, input int p);
    exp_t e;
    nCompared++;
    if (sbq.size() == 0) begin
      nMismatched++;
      $display("FAIL %s frame%0d cyc%0d: scoreboard empty, got anode=%b bcd=%h", tag, f, p, anode, bcd);
    end else begin
      e = sbq.pop_front();
      if (anode !== e.anode || bcd !== e.bcd || dp !== e.dp || frame_start !== e.fs) begin
        nMismatched++;
        $display("FAIL %s frame%0d cyc%0d: got anode=%b bcd=%h dp=%b fs=%b, want anode=%b bcd=%h dp=%b fs=%b",
                 tag, f, p, anode, bcd, dp, frame_start, e.anode, e.bcd, e.dp, e.fs);
      end
    end
  endtask

  task automatic checkReset(input string tag);
    nCompared++;
    if (anode !== 4'hF || bcd !== 4'h0 || dp !== 1'b1 || frame_start !== 1'b0) begin
      nMismatched++;
      $display("FAIL %s: got anode=%b bcd=%h dp=%b fs=%b, want anode=1111 bcd=0 dp=1 fs=0",
               tag, anode, bcd, dp, frame_start);
    end
  endtask

  initial begin
    vecs[0] = '{16'h4321, 4'b0010, 4'hF,    4'b0001, 16'h4321, 4'b1101, 4'b1111};
    vecs[1] = '{16'hABCD, 4'b0000, 4'hF,    4'b0001, 16'hABCD, 4'b1111, 4'b1111};
    vecs[2] = '{16'h8765, 4'b1001, 4'b0101, 4'b0001, 16'h8765, 4'b0110, 4'b0101};
    vecs[3] = '{16'h0F0A, 4'b1111, 4'b0000, 4'b0001, 16'h0F0A, 4'b0000, 4'b0000};
    vecs[4] = '{16'h9E5C, 4'b0100, 4'b1010, 4'b0001, 16'h9E5C, 4'b1011, 4'b1010};
    vecs[5] = '{16'h1357, 4'b1000, 4'hF,    4'b0001, 16'h1357, 4'b0111, 4'b1111};

    rst = 1'b1;
    driveVec(vecs[0]);
    repeat (3) begin
      @(negedge clk);
      checkReset("reset");
    end
    rst = 1'b0;
    pushFrame(vecs[0], 0);

    // Table rows: junk mid-frame must stay invisible; the row for the next frame lands during slot 1.
    for (int f = 0; f < NV; f++) begin
      for (int p = 0; p < FRAME; p++) begin
        @(negedge clk);
        checkCycle("scan", f, p);
        if (f < NV - 1) begin
          if (p == 3) begin
            digits     = 16'($urandom);
            dp_mask    = 4'($urandom);
            en_mask    = 4'($urandom);
            blink_mask = 4'($urandom);
          end
          if (p == 9) begin
            driveVec(vecs[f + 1]);
            pushFrame(vecs[f + 1], f + 1);
          end
        end
      end
    end

    // Reset during the 3rd SHOW cycle of digit 2, then a clean restart from INIT.
    pushFrame(vecs[NV - 1], NV);
    for (int p = 0; p <= 2 * SLOT + BLK + 2; p++) begin
      @(negedge clk);
      checkCycle("preReset", NV, p);
    end
    rst = 1'b1;
    sbq.delete();
    @(negedge clk);
    checkReset("midReset");
    rst = 1'b0;
    pushFrame(vecs[NV - 1], 0);
    for (int p = 0; p < FRAME; p++) begin
      @(negedge clk);
      checkCycle("restart", 0, p);
    end

    nCompared++;
    if (sbq.size() != 0) begin
      nMismatched++;
      $display("FAIL leftover: got %0d queued entries, want 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
